// File: rtl/stopwatch_time_counter.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_time_counter
// Brief    : Cascaded seconds/minutes counter, up or down, with preset load
//            and a wrap or saturate policy at the ends of the range.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_time_counter #(
    parameter int SEC_MOD = 60,
    parameter int MIN_MOD = 100,
    parameter int SEC_W   = 6,
    parameter int MIN_W   = 7,
    parameter int WRAP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             run,
    input  logic             dir,
    input  logic             load,
    input  logic [MIN_W-1:0] load_min,
    input  logic [SEC_W-1:0] load_sec,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             sec_carry,
    output logic             wrap,
    output logic             at_limit
);

    localparam logic [SEC_W-1:0] C_SEC_MAX = SEC_W'(SEC_MOD - 1);
    localparam logic [MIN_W-1:0] C_MIN_MAX = MIN_W'(MIN_MOD - 1);
    localparam logic [SEC_W-1:0] C_SEC_ONE = SEC_W'(1);
    localparam logic [MIN_W-1:0] C_MIN_ONE = MIN_W'(1);
    localparam logic             C_WRAP_EN = (WRAP != 0);

    logic [MIN_W-1:0] r_min;
    logic [SEC_W-1:0] r_sec;
    logic             r_carry;
    logic             r_wrap;

    logic [MIN_W-1:0] w_min_nxt;
    logic [SEC_W-1:0] w_sec_nxt;
    logic             w_carry_nxt;
    logic             w_wrap_nxt;
    logic             w_count;

    // A tick coincident with load is dropped rather than deferred.
    assign w_count = tick && run && !load;

    always_comb begin
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        w_carry_nxt = 1'b0;
        w_wrap_nxt  = 1'b0;
        if (load) begin
            w_min_nxt = (load_min > C_MIN_MAX) ? C_MIN_MAX : load_min;
            w_sec_nxt = (load_sec > C_SEC_MAX) ? C_SEC_MAX : load_sec;
        end else if (w_count) begin
            if (!dir) begin
                if (r_sec < C_SEC_MAX) begin
                    w_sec_nxt = r_sec + C_SEC_ONE;
                end else if (r_min < C_MIN_MAX) begin
                    w_sec_nxt   = '0;
                    w_min_nxt   = r_min + C_MIN_ONE;
                    w_carry_nxt = 1'b1;
                end else if (C_WRAP_EN) begin
                    w_sec_nxt   = '0;
                    w_min_nxt   = '0;
                    w_carry_nxt = 1'b1;
                    w_wrap_nxt  = 1'b1;
                end
            end else begin
                if (r_sec != '0) begin
                    w_sec_nxt = r_sec - C_SEC_ONE;
                end else if (r_min != '0) begin
                    w_sec_nxt   = C_SEC_MAX;
                    w_min_nxt   = r_min - C_MIN_ONE;
                    w_carry_nxt = 1'b1;
                end else if (C_WRAP_EN) begin
                    w_sec_nxt   = C_SEC_MAX;
                    w_min_nxt   = C_MIN_MAX;
                    w_carry_nxt = 1'b1;
                    w_wrap_nxt  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_min   <= '0;
            r_sec   <= '0;
            r_carry <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_min   <= w_min_nxt;
            r_sec   <= w_sec_nxt;
            r_carry <= w_carry_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign minutes   = r_min;
    assign seconds   = r_sec;
    assign sec_carry = r_carry;
    assign wrap      = r_wrap;

    // Decoded from registered counts so it tracks a dir change immediately.
    assign at_limit = dir ? ((r_min == '0) && (r_sec == '0))
                          : ((r_min == C_MIN_MAX) && (r_sec == C_SEC_MAX));

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_time_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_time_counter
// Brief    : Directed bench; one wrapping and one saturating counter share
//            the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_time_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       run = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [6:0] load_min = '0;
    logic [5:0] load_sec = '0;

    logic [6:0] w_min_w, w_min_s;
    logic [5:0] w_sec_w, w_sec_s;
    logic       w_carry_w, w_carry_s, w_wrap_w, w_wrap_s, w_lim_w, w_lim_s;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    stopwatch_time_counter #(.SEC_MOD(60), .MIN_MOD(100), .SEC_W(6), .MIN_W(7), .WRAP(1)) u_wrap (
        .clk(clk), .reset(reset), .tick(tick), .run(run), .dir(dir), .load(load),
        .load_min(load_min), .load_sec(load_sec), .minutes(w_min_w), .seconds(w_sec_w),
        .sec_carry(w_carry_w), .wrap(w_wrap_w), .at_limit(w_lim_w)
    );

    stopwatch_time_counter #(.SEC_MOD(60), .MIN_MOD(100), .SEC_W(6), .MIN_W(7), .WRAP(0)) u_sat (
        .clk(clk), .reset(reset), .tick(tick), .run(run), .dir(dir), .load(load),
        .load_min(load_min), .load_sec(load_sec), .minutes(w_min_s), .seconds(w_sec_s),
        .sec_carry(w_carry_s), .wrap(w_wrap_s), .at_limit(w_lim_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input int m, input int s, input int c, input int w, input int l);
        chk({tag, ".wrap.min"},   {25'd0, w_min_w},   m);
        chk({tag, ".wrap.sec"},   {26'd0, w_sec_w},   s);
        chk({tag, ".wrap.carry"}, {31'd0, w_carry_w}, c);
        chk({tag, ".wrap.wrap"},  {31'd0, w_wrap_w},  w);
        chk({tag, ".wrap.limit"}, {31'd0, w_lim_w},   l);
    endtask

    task automatic chk_s(input string tag, input int m, input int s, input int c, input int w, input int l);
        chk({tag, ".sat.min"},   {25'd0, w_min_s},   m);
        chk({tag, ".sat.sec"},   {26'd0, w_sec_s},   s);
        chk({tag, ".sat.carry"}, {31'd0, w_carry_s}, c);
        chk({tag, ".sat.wrap"},  {31'd0, w_wrap_s},  w);
        chk({tag, ".sat.limit"}, {31'd0, w_lim_s},   l);
    endtask

    task automatic do_load(input int m, input int s);
        load     = 1'b1;
        load_min = 7'(m);
        load_sec = 6'(s);
        step();
        load     = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        reset = 1'b0;
        chk_w("reset", 0, 0, 0, 0, 0);
        chk_s("reset", 0, 0, 0, 0, 0);

        // Count up 60 ticks: seconds 1..59 then 0 with one carry
        run = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            tick = 1'b1;
            step();
            chk("up.sec", {26'd0, w_sec_w}, i % 60);
            chk("up.carry", {31'd0, w_carry_w}, (i == 60) ? 1 : 0);
        end
        tick = 1'b0;
        chk_w("up60", 1, 0, 1, 0, 0);
        chk_s("up60", 1, 0, 1, 0, 0);
        step();
        chk_w("up60.idle", 1, 0, 0, 0, 0);

        // Top of range, counting up
        do_load(99, 58);
        chk_w("ld9958", 99, 58, 0, 0, 0);
        tick = 1'b1;
        step();
        chk_w("up9959", 99, 59, 0, 0, 1);
        chk_s("up9959", 99, 59, 0, 0, 1);
        step();
        chk_w("upwrap", 0, 0, 1, 1, 0);
        chk_s("uphold", 99, 59, 0, 0, 1);
        tick = 1'b0;
        step();
        chk_w("upwrap.idle", 0, 0, 0, 0, 0);
        tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_s("uphold5", 99, 59, 0, 0, 1);
        end
        tick = 1'b0;

        // Count down from 1:00
        dir = 1'b1;
        do_load(1, 0);
        chk_w("ld0100", 1, 0, 0, 0, 0);
        tick = 1'b1;
        step();
        chk_w("dn0059", 0, 59, 1, 0, 0);
        chk_s("dn0059", 0, 59, 1, 0, 0);
        for (int i = 1; i <= 59; i++) begin
            step();
            chk("dn.sec", {26'd0, w_sec_w}, 59 - i);
            chk("dn.carry", {31'd0, w_carry_w}, 0);
        end
        chk_w("dn0000", 0, 0, 0, 0, 1);
        chk_s("dn0000", 0, 0, 0, 0, 1);
        step();
        chk_w("dnwrap", 99, 59, 1, 1, 0);
        chk_s("dnhold", 0, 0, 0, 0, 1);
        tick = 1'b0;

        // Clamp (seconds field is 6 bits, so 63 is the largest out-of-range preset)
        dir = 1'b0;
        do_load(120, 63);
        chk_w("clamp", 99, 59, 0, 0, 1);
        chk_s("clamp", 99, 59, 0, 0, 1);

        // Load beats a coincident tick
        tick = 1'b1;
        do_load(5, 10);
        chk_w("ldtick", 5, 10, 0, 0, 0);

        // Direction change on the tick cycle uses the new direction
        dir = 1'b1;
        step();
        chk_w("dirchg", 5, 9, 0, 0, 0);

        // run=0 ignores ticks
        dir = 1'b0;
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_w("runlow", 5, 9, 0, 0, 0);
        end
        run = 1'b1;
        tick = 1'b0;

        // Mid-range minute carry
        do_load(12, 59);
        tick = 1'b1;
        step();
        chk_w("carry1300", 13, 0, 1, 0, 0);
        tick = 1'b0;

        // Reset with a pending tick
        do_load(12, 34);
        tick  = 1'b1;
        reset = 1'b1;
        step();
        chk_w("rst1234", 0, 0, 0, 0, 0);
        do_load(12, 59);
        reset = 1'b1;
        step();
        chk_w("rstcarry", 0, 0, 0, 0, 0);
        chk_s("rstcarry", 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();
        chk_w("resume", 0, 1, 0, 0, 0);
        tick = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
